msfsm_choice_arbiter: RTL and testbench



---
 rtl/msfsm_pkg.sv | 17 +
 rtl/msfsm_rr_picker.sv | 24 ++
 rtl/msfsm_choice_arbiter.sv | 90 +++++++++
 tb/tb_msfsm_choice_arbiter.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/msfsm_pkg.sv
// Shared constants and helpers for the MSFSM choice-place arbiter.
// Width helpers and parameter legality checks.
package msfsm_pkg;

  function automatic int clog2w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic bit init_marked_ok(input int v);
    return (v == 0) || (v == 1);
  endfunction

  localparam int N_REQ_DEF = 4;
  localparam int RR_PTR_W = clog2w(N_REQ_DEF);
  localparam bit INIT_OK_DEF = init_marked_ok(1);

endpackage

// File: rtl/msfsm_rr_picker.sv
// Round-robin one-hot picker for the choice place.
// Rotate req by ptr, isolate lowest set bit, rotate back.
module msfsm_rr_picker
  import msfsm_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int W     = clog2w(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [W-1:0]     rr_ptr,
  output logic [N_REQ-1:0] grant
);

  logic [N_REQ-1:0] rot;
  logic [N_REQ-1:0] low;

  // Priority search starting at rr_ptr, wrapping modulo N_REQ.
  always_comb begin
    rot   = N_REQ'({req, req} >> rr_ptr);
    low   = rot & (~rot + N_REQ'(1));
    grant = N_REQ'(({low, low} << rr_ptr) >> N_REQ);
  end

endmodule

// File: rtl/msfsm_choice_arbiter.sv
// Token holder and round-robin arbiter for one free-choice place.
// Grant is Mealy on req; produced tokens are grantable next cycle.
module msfsm_choice_arbiter
  import msfsm_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int N_PROD      = 2,
  parameter int INIT_MARKED = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_PROD-1:0] prod_ev,
  input  logic [N_REQ-1:0]  req,
  output logic [N_REQ-1:0]  grant,
  output logic              marked,
  output logic [N_REQ-1:0]  last_grant,
  output logic              safe_err
);

  localparam int W = clog2w(N_REQ);
  localparam bit INIT_LEGAL = init_marked_ok(INIT_MARKED);
  localparam logic INIT_BIT = INIT_MARKED[0];

  if (!INIT_LEGAL) begin : g_bad_init
    $error("INIT_MARKED must be 0 or 1");
  end

  logic [W-1:0]     rr_ptr;
  logic [W-1:0]     ptr_nxt;
  logic [W-1:0]     gidx;
  logic [N_REQ-1:0] pick;
  logic             cons;
  logic             prod;
  logic             multi;
  logic             marked_nxt;
  logic             err_nxt;

  msfsm_rr_picker #(
    .N_REQ (N_REQ),
    .W     (W)
  ) u_pick (
    .req    (req),
    .rr_ptr (rr_ptr),
    .grant  (pick)
  );

  // Gate the pick with token presence and reset.
  always_comb begin
    grant = '0;
    if (!reset && marked) grant = pick;
  end

  // Next marking, pointer and error flag.
  always_comb begin
    cons  = |grant;
    prod  = |prod_ev;
    multi = |(prod_ev & (prod_ev - N_PROD'(1)));
    gidx  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) gidx = W'(i);
    end
    ptr_nxt = rr_ptr;
    if (cons) begin
      if (gidx == W'(N_REQ - 1)) ptr_nxt = '0;
      else ptr_nxt = gidx + W'(1);
    end
    marked_nxt = marked;
    if (prod) marked_nxt = 1'b1;
    else if (cons) marked_nxt = 1'b0;
    err_nxt = safe_err;
    if (multi) err_nxt = 1'b1;
    if (marked && !cons && prod) err_nxt = 1'b1;
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      marked     <= INIT_BIT;
      rr_ptr     <= '0;
      last_grant <= '0;
      safe_err   <= 1'b0;
    end else begin
      marked     <= marked_nxt;
      rr_ptr     <= ptr_nxt;
      last_grant <= grant;
      safe_err   <= err_nxt;
    end
  end

endmodule

// File: tb/tb_msfsm_choice_arbiter.sv
// Bench for msfsm_choice_arbiter: token-level model plus directed
// literal checks, and a 3-request instance for wrap behaviour.
module tb_msfsm_choice_arbiter;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] req = '0;
  logic [1:0] prod_ev = '0;
  logic [3:0] grant;
  logic       marked;
  logic [3:0] last_grant;
  logic       safe_err;

  logic [2:0] req3 = '0;
  logic [1:0] prod3 = '0;
  logic [2:0] grant3;
  logic       marked3;
  logic [2:0] last3;
  logic       err3;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  msfsm_choice_arbiter #(
    .N_REQ(4), .N_PROD(2), .INIT_MARKED(1)
  ) dut (
    .clk(clk), .reset(reset), .prod_ev(prod_ev), .req(req),
    .grant(grant), .marked(marked), .last_grant(last_grant),
    .safe_err(safe_err)
  );

  msfsm_choice_arbiter #(
    .N_REQ(3), .N_PROD(2), .INIT_MARKED(1)
  ) dut3 (
    .clk(clk), .reset(reset), .prod_ev(prod3), .req(req3),
    .grant(grant3), .marked(marked3), .last_grant(last3),
    .safe_err(err3)
  );

  // Token-level model of the 4-request instance.
  bit       m_marked;
  int       m_ptr;
  bit [3:0] m_last;
  bit       m_err;
  bit       chk_en = 1'b0;

  function automatic bit [3:0] model_grant();
    bit [3:0] g;
    g = '0;
    if (!reset && m_marked) begin
      for (int k = 0; k < 4; k++) begin
        int idx;
        idx = (m_ptr + k) % 4;
        if (req[idx] && g == 0) g[idx] = 1'b1;
      end
    end
    return g;
  endfunction

  always @(posedge clk) begin
    bit [3:0] g;
    int np;
    g = model_grant();
    np = $countones(prod_ev);
    if (reset) begin
      m_marked = 1'b1;
      m_ptr = 0;
      m_last = '0;
      m_err = 1'b0;
    end else begin
      m_last = g;
      for (int i = 0; i < 4; i++) if (g[i]) m_ptr = (i + 1) % 4;
      if (np > 1) m_err = 1'b1;
      if (m_marked && g == 0 && np > 0) m_err = 1'b1;
      if (np > 0) m_marked = 1'b1;
      else if (g != 0) m_marked = 1'b0;
    end
    chk_en = 1'b1;
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      bit [3:0] eg;
      eg = model_grant();
      n_chk++;
      if (grant !== eg) begin
        n_fail++;
        $display("FAIL model_grant: got %b expected %b", grant, eg);
      end
      n_chk++;
      if (marked !== m_marked) begin
        n_fail++;
        $display("FAIL model_marked: got %b expected %b", marked, m_marked);
      end
      n_chk++;
      if (last_grant !== m_last) begin
        n_fail++;
        $display("FAIL model_last: got %b expected %b", last_grant, m_last);
      end
      n_chk++;
      if (safe_err !== m_err) begin
        n_fail++;
        $display("FAIL model_err: got %b expected %b", safe_err, m_err);
      end
    end
  end

  task automatic chk(input string nm, input logic [3:0] act,
                     input logic [3:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] r, input logic [1:0] p,
                       input logic rs, input logic [2:0] r3 = 3'b000,
                       input logic [1:0] p3 = 2'b00);
    @(posedge clk);
    #1;
    req = r;
    prod_ev = p;
    reset = rs;
    req3 = r3;
    prod3 = p3;
    @(negedge clk);
    #1;
  endtask

  initial begin
    drive(4'b0000, 2'b00, 1'b1);
    drive(4'b0000, 2'b00, 1'b1);
    // Reset state.
    drive(4'b0000, 2'b00, 1'b0);
    chk("rst_grant", grant, 4'b0000);
    chk("rst_marked", {3'b0, marked}, 4'b0001);
    chk("rst_err", {3'b0, safe_err}, 4'b0000);
    // Wrap on the 3-request instance.
    drive(4'b0000, 2'b00, 1'b0, 3'b010, 2'b01);
    chk("n3_first", {1'b0, grant3}, 4'b0010);
    drive(4'b0000, 2'b00, 1'b0, 3'b011, 2'b01);
    chk("n3_wrap", {1'b0, grant3}, 4'b0001);
    drive(4'b0000, 2'b00, 1'b0, 3'b011, 2'b00);
    chk("n3_ptr1", {1'b0, grant3}, 4'b0010);
    drive(4'b0000, 2'b00, 1'b0, 3'b000, 2'b01);
    drive(4'b0000, 2'b00, 1'b0, 3'b100, 2'b01);
    chk("n3_idx2", {1'b0, grant3}, 4'b0100);
    drive(4'b0000, 2'b00, 1'b0, 3'b111, 2'b00);
    chk("n3_ptr0", {1'b0, grant3}, 4'b0001);
    // First grant, same-cycle.
    drive(4'b0110, 2'b00, 1'b0);
    chk("first_grant", grant, 4'b0010);
    drive(4'b0000, 2'b00, 1'b0);
    chk("first_marked", {3'b0, marked}, 4'b0000);
    chk("first_last", last_grant, 4'b0010);
    chk("no_token", grant, 4'b0000);
    drive(4'b0000, 2'b01, 1'b0);
    drive(4'b0111, 2'b00, 1'b0);
    chk("ptr_is_2", grant, 4'b0100);
    // Fairness from a fresh pointer.
    drive(4'b0000, 2'b00, 1'b1);
    begin
      logic [3:0] seq [5];
      seq[0] = 4'b0001; seq[1] = 4'b0010; seq[2] = 4'b0100;
      seq[3] = 4'b1000; seq[4] = 4'b0001;
      for (int i = 0; i < 5; i++) begin
        drive(4'b1111, 2'b01, 1'b0);
        chk("rr_seq", grant, seq[i]);
      end
    end
    // Consume and re-produce together.
    drive(4'b0001, 2'b01, 1'b0);
    chk("cp_grant", grant, 4'b0001);
    drive(4'b0100, 2'b00, 1'b0);
    chk("cp_next", grant, 4'b0100);
    chk("cp_marked", {3'b0, marked}, 4'b0001);
    chk("cp_err", {3'b0, safe_err}, 4'b0000);
    // Two tokens in the place.
    drive(4'b0000, 2'b10, 1'b0);
    drive(4'b0000, 2'b10, 1'b0);
    drive(4'b0000, 2'b00, 1'b0);
    chk("two_tok_err", {3'b0, safe_err}, 4'b0001);
    drive(4'b0000, 2'b00, 1'b0);
    chk("err_sticky", {3'b0, safe_err}, 4'b0001);
    // Double producer while empty.
    drive(4'b0000, 2'b00, 1'b1);
    drive(4'b0001, 2'b00, 1'b0);
    chk("clr_err", {3'b0, safe_err}, 4'b0000);
    drive(4'b0000, 2'b11, 1'b0);
    drive(4'b0000, 2'b00, 1'b0);
    chk("dbl_err", {3'b0, safe_err}, 4'b0001);
    chk("dbl_marked", {3'b0, marked}, 4'b0001);
    // Reset during a would-be grant.
    drive(4'b1000, 2'b00, 1'b1);
    chk("rst_supp", grant, 4'b0000);
    drive(4'b0000, 2'b00, 1'b0);
    chk("rst2_marked", {3'b0, marked}, 4'b0001);
    chk("rst2_last", last_grant, 4'b0000);
    chk("rst2_err", {3'b0, safe_err}, 4'b0000);
    drive(4'b1001, 2'b00, 1'b0);
    chk("rst2_ptr0", grant, 4'b0001);
    drive(4'b0000, 2'b00, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
